// File: rtl/frame_rx_if.sv
// Received-word handshake between the frame receiver and its consumer.
interface frame_rx_if #(
  parameter int N = 8
);
  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_rx_ctrl.sv
// Oversampled serial frame receiver controller. It sequences an external
// shift register (clear / shift-enable / serial bit) and publishes the
// completed word through a valid/ready handshake with sticky error flags.
//
// state | meaning
// IDLE  | line idle, waiting for rx low (start edge)
// START | counting to mid start bit, confirming it is still low
// DATA  | sampling N data bits at mid-bit, one shift per bit
// STOP  | sampling the stop bit, delivering the word
module frame_rx_ctrl #(
  parameter int N   = 8,
  parameter int OVS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         rx,
  input  logic [N-1:0] sr_q,
  output logic         sr_in,
  output logic         sr_en,
  output logic         sr_clear,
  frame_rx_if.master   word,
  output logic         frame_err,
  output logic         overrun,
  input  logic         err_clr
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(N + 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic          stop_smp;
  logic          ferr_set, ovr_set;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
    end
  end

  // Next-state, counter updates and shift register strobes.
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    sr_en    = 1'b0;
    sr_in    = 1'b0;
    sr_clear = 1'b0;
    stop_smp = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          sr_clear = 1'b1;
          tick_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == T_HALF) begin
            if (!rx) begin
              tick_nx  = '0;
              bit_nx   = '0;
              state_nx = DATA;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == T_FULL) begin
            sr_en   = 1'b1;
            sr_in   = rx;
            bit_nx  = bit_cnt + BW'(1);
            tick_nx = '0;
            if (bit_cnt == B_LAST) state_nx = STOP;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == T_FULL) begin
            stop_smp = 1'b1;
            tick_nx  = '0;
            state_nx = IDLE;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset holds the external register cleared and suppresses any shift.
    if (reset) begin
      sr_en    = 1'b0;
      sr_in    = 1'b0;
      sr_clear = 1'b1;
      stop_smp = 1'b0;
    end
  end

  assign ferr_set = stop_smp & ~rx;
  assign ovr_set  = stop_smp & word.valid & ~word.ready;

  // Word delivery and valid/ready handshake; a new word wins over consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      word.data  <= '0;
      word.valid <= 1'b0;
    end else if (stop_smp) begin
      word.data  <= sr_q;
      word.valid <= 1'b1;
    end else if (word.valid && word.ready) begin
      word.valid <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_rx_ctrl.sv
// Directed bench for frame_rx_ctrl with a behavioural external shift register.
module tb_frame_rx_ctrl;
  localparam int N   = 8;
  localparam int OVS = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic         rx = 1'b1;
  logic [N-1:0] sr_q;
  logic         sr_in, sr_en, sr_clear;
  logic         frame_err, overrun;
  logic         err_clr = 1'b0;
  logic [N-1:0] sr_model = '0;

  frame_rx_if #(.N(N)) bus ();

  frame_rx_ctrl #(.N(N), .OVS(OVS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx), .sr_q(sr_q),
    .sr_in(sr_in), .sr_en(sr_en), .sr_clear(sr_clear), .word(bus.master),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  int compared = 0;
  int mismatched = 0;
  int div = 1;
  int tphase = 0;
  int cyc = 0;
  int en_cnt = 0;
  int both_cnt = 0;
  int vcyc_cnt = 0;
  int rise_cyc = 0;
  int drop_cyc = 0;
  logic v_prev = 1'b0;

  always #5 clk = ~clk;

  // Tick strobe: one high cycle every div cycles.
  always @(negedge clk) begin
    if (tphase >= div - 1) begin
      tick = 1'b1;
      tphase = 0;
    end else begin
      tick = 1'b0;
      tphase++;
    end
  end

  // External shift register and event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr_clear) sr_model <= '0;
    else if (sr_en) sr_model <= {sr_model[N-2:0], sr_in};
    if (sr_en) en_cnt <= en_cnt + 1;
    if (sr_en && sr_clear) both_cnt <= both_cnt + 1;
  end
  assign sr_q = sr_model;

  always @(negedge clk) begin
    if (bus.valid) vcyc_cnt = vcyc_cnt + 1;
    if (bus.valid && !v_prev) rise_cyc = cyc;
    v_prev = bus.valid;
  end

  // Drives one frame MSB-first; ready pulses high for one cycle at rdy_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at);
    int k;
    logic v;
    k = 0;
    drop_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = stop;
      else v = b[8-i];
      rx = v;
      repeat (OVS * div) begin
        @(negedge clk);
        k++;
        if (k == rdy_at) bus.ready = 1'b1;
        if (k == rdy_at + 1) bus.ready = 1'b0;
      end
    end
    rx = 1'b1;
    repeat (32 * div) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared += 6;
    if (sr_clear !== 1'b1) begin mismatched++; $display("FAIL reset_sr_clear got %b want 1", sr_clear); end
    if (sr_en !== 1'b0) begin mismatched++; $display("FAIL reset_sr_en got %b want 0", sr_en); end
    if (sr_in !== 1'b0) begin mismatched++; $display("FAIL reset_sr_in got %b want 0", sr_in); end
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    if (bus.data !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", bus.data); end
    if ({frame_err, overrun} !== 2'b00) begin mismatched++; $display("FAIL reset_flags got %b want 00", {frame_err, overrun}); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int e0, v0;
    bus.ready = 1'b1;
    e0 = en_cnt; v0 = vcyc_cnt;
    send_frame(8'hA5, 1'b1, -1);
    compared += 6;
    if (en_cnt - e0 !== 8) begin mismatched++; $display("FAIL basic_sr_en_count got %0d want 8", en_cnt - e0); end
    if (bus.data !== 8'hA5) begin mismatched++; $display("FAIL basic_data got %h want a5", bus.data); end
    if (vcyc_cnt - v0 !== 1) begin mismatched++; $display("FAIL basic_valid_cycles got %0d want 1", vcyc_cnt - v0); end
    if (rise_cyc - drop_cyc !== 153) begin mismatched++; $display("FAIL basic_latency got %0d want 153", rise_cyc - drop_cyc); end
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL basic_frame_err got %b want 0", frame_err); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_glitch();
    int e0, v0;
    e0 = en_cnt; v0 = vcyc_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    compared += 2;
    if (en_cnt - e0 !== 0) begin mismatched++; $display("FAIL glitch_sr_en_count got %0d want 0", en_cnt - e0); end
    if (vcyc_cnt - v0 !== 0 || bus.valid !== 1'b0) begin mismatched++; $display("FAIL glitch_valid got %0d cycles want 0", vcyc_cnt - v0); end
  endtask

  task automatic test_frame_err();
    int v0;
    v0 = vcyc_cnt;
    send_frame(8'h3C, 1'b0, -1);
    compared += 4;
    if (bus.data !== 8'h3C) begin mismatched++; $display("FAIL ferr_data got %h want 3c", bus.data); end
    if (vcyc_cnt - v0 !== 1) begin mismatched++; $display("FAIL ferr_valid_cycles got %0d want 1", vcyc_cnt - v0); end
    if (frame_err !== 1'b1) begin mismatched++; $display("FAIL ferr_set got %b want 1", frame_err); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL ferr_overrun got %b want 0", overrun); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL ferr_clear got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    compared += 3;
    if (bus.data !== 8'h11) begin mismatched++; $display("FAIL ovr_first_data got %h want 11", bus.data); end
    if (bus.valid !== 1'b1) begin mismatched++; $display("FAIL ovr_first_valid got %b want 1", bus.valid); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_first_flag got %b want 0", overrun); end
    send_frame(8'h22, 1'b1, -1);
    compared += 3;
    if (bus.data !== 8'h22) begin mismatched++; $display("FAIL ovr_second_data got %h want 22", bus.data); end
    if (bus.valid !== 1'b1) begin mismatched++; $display("FAIL ovr_second_valid got %b want 1", bus.valid); end
    if (overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_set got %b want 1", overrun); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_clear got %b want 0", overrun); end
    // ready high exactly on the stop-sample edge
    send_frame(8'h33, 1'b1, 152);
    compared += 3;
    if (bus.data !== 8'h33) begin mismatched++; $display("FAIL coincide_data got %h want 33", bus.data); end
    if (bus.valid !== 1'b1) begin mismatched++; $display("FAIL coincide_valid got %b want 1", bus.valid); end
    if (overrun !== 1'b0) begin mismatched++; $display("FAIL coincide_overrun got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int e0, v0;
    logic [3:0] bits;
    bits = 4'b0101;
    e0 = en_cnt;
    rx = 1'b0;
    repeat (OVS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = bits[i];
      repeat (OVS) @(negedge clk);
    end
    rx = bits[3];
    repeat (OVS / 2) @(negedge clk);
    compared++;
    if (en_cnt - e0 !== 3) begin mismatched++; $display("FAIL midrst_pre_shifts got %0d want 3", en_cnt - e0); end
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared += 6;
    if (bus.data !== 8'h00) begin mismatched++; $display("FAIL midrst_data got %h want 00", bus.data); end
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", bus.valid); end
    if ({frame_err, overrun} !== 2'b00) begin mismatched++; $display("FAIL midrst_flags got %b want 00", {frame_err, overrun}); end
    if (sr_clear !== 1'b1) begin mismatched++; $display("FAIL midrst_sr_clear got %b want 1", sr_clear); end
    if (sr_en !== 1'b0) begin mismatched++; $display("FAIL midrst_sr_en got %b want 0", sr_en); end
    if (sr_in !== 1'b0) begin mismatched++; $display("FAIL midrst_sr_in got %b want 0", sr_in); end
    reset = 1'b0;
    bus.ready = 1'b1;
    repeat (8) @(negedge clk);
    e0 = en_cnt; v0 = vcyc_cnt;
    send_frame(8'hFF, 1'b1, -1);
    compared += 4;
    if (en_cnt - e0 !== 8) begin mismatched++; $display("FAIL midrst_ff_shifts got %0d want 8", en_cnt - e0); end
    if (bus.data !== 8'hFF) begin mismatched++; $display("FAIL midrst_ff_data got %h want ff", bus.data); end
    if (vcyc_cnt - v0 !== 1) begin mismatched++; $display("FAIL midrst_ff_valid_cycles got %0d want 1", vcyc_cnt - v0); end
    if ({frame_err, overrun} !== 2'b00) begin mismatched++; $display("FAIL midrst_ff_flags got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_slow_tick();
    int e0, v0;
    div = 3;
    repeat (6) @(negedge clk);
    e0 = en_cnt; v0 = vcyc_cnt;
    send_frame(8'h00, 1'b1, -1);
    compared += 4;
    if (en_cnt - e0 !== 8) begin mismatched++; $display("FAIL slow_sr_en_count got %0d want 8", en_cnt - e0); end
    if (bus.data !== 8'h00) begin mismatched++; $display("FAIL slow_data got %h want 00", bus.data); end
    if (vcyc_cnt - v0 !== 1) begin mismatched++; $display("FAIL slow_valid_cycles got %0d want 1", vcyc_cnt - v0); end
    if ({frame_err, overrun} !== 2'b00) begin mismatched++; $display("FAIL slow_flags got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_exclusive_strobes();
    compared++;
    if (both_cnt !== 0) begin mismatched++; $display("FAIL en_clear_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    bus.ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_slow_tick();
    test_exclusive_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/frame_rx_ctrl.md
FRAME_RX_CTRL -- requirements
Module: frame_rx_ctrl

Interface
REQ-001 Parameter N, default 8, data bits per frame and width of the controlled shift register; legal N >= 2.
REQ-002 Parameter OVS, default 16, sample ticks per bit period; legal OVS >= 4, even.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle sample strobe, OVS strobes per bit period.
REQ-006 rx  input  1  serial line, idle high, already synchronised to clk.
REQ-007 sr_q  input  N  parallel contents of the external shift register.
REQ-008 sr_in  output  1  serial bit presented to the shift register.
REQ-009 sr_en  output  1  one-cycle shift enable to the shift register.
REQ-010 sr_clear  output  1  one-cycle synchronous clear to the shift register.
REQ-011 data  output  N  received word.
REQ-012 valid  output  1  data holds an unconsumed word.
REQ-013 ready  input  1  consumer accepts data when valid and ready are both high.
REQ-014 frame_err  output  1  sticky: a stop bit was sampled low.
REQ-015 overrun  output  1  sticky: a frame completed while valid was still high.
REQ-016 err_clr  input  1  one-cycle clear of frame_err and overrun.

Function
REQ-017 Frame format: 1 start bit (low), N data bits MSB-first, 1 stop bit (high); the first data bit ends at sr_q[N-1].
REQ-018 FSM states IDLE, START, DATA, STOP; only tick-qualified cycles advance counters.
REQ-019 IDLE: on any cycle with rx=0, assert sr_clear for that cycle, zero tick counter, go to START.
REQ-020 START: on the tick that brings the tick counter to OVS/2-1, sample rx; rx=0 -> zero tick counter, zero bit counter, go to DATA; rx=1 -> glitch, return to IDLE with no other effect.
REQ-021 DATA: on every tick that brings the tick counter to OVS-1, drive sr_in=rx, assert sr_en for exactly that cycle, increment bit counter, zero tick counter.
REQ-022 DATA: after the shift with bit counter equal to N-1, go to STOP; exactly N sr_en pulses occur per accepted frame.
REQ-023 STOP: on the tick that brings the tick counter to OVS-1, sample rx, load data<=sr_q, go to IDLE; rx=0 additionally sets frame_err.
REQ-024 Word is delivered (data loaded, valid set) even when frame_err is set in the same frame.
REQ-025 valid rises the cycle after the STOP sample and stays high until a cycle with ready=1, then clears the next cycle.
REQ-026 If the STOP sample occurs while valid=1 and ready=0, data is overwritten, valid stays high, overrun sets.
REQ-027 If the STOP sample coincides with valid=1 and ready=1, the old word is consumed, the new word loads, valid stays high, overrun does not set.
REQ-028 err_clr clears both sticky flags; if a set event occurs in the same cycle, set wins.
REQ-029 sr_en and sr_clear are never high in the same cycle; sr_en is low outside DATA.
REQ-030 tick counter width ceil(log2(OVS)), bit counter width ceil(log2(N+1)); both wrap only by explicit zeroing.
REQ-031 rx changes between ticks are ignored except for the IDLE start detection.
REQ-032 Latency: valid rises (N+1)*OVS + OVS/2 ticks after the first tick following start detection, plus one clk.

Reset
REQ-033 reset=1 forces state IDLE, counters 0, data=0, valid=0, frame_err=0, overrun=0, sr_en=0, sr_in=0, and sr_clear=1 in each cycle reset is asserted.
REQ-034 reset overrides all other inputs; reset mid-frame abandons the frame with no valid, no flag update.

Verification
REQ-035 N=8, OVS=16, tick every cycle, send 0xA5 with good stop, ready=1 -> exactly 8 sr_en pulses, data=0xA5, valid high 1 cycle, no flags.
REQ-036 rx low for 4 ticks then high (glitch) -> return to IDLE, no sr_en, valid stays 0.
REQ-037 Send 0x3C with stop bit low -> data=0x3C, valid=1, frame_err=1; err_clr pulse -> frame_err=0.
REQ-038 ready=0, send 0x11 then 0x22 -> data=0x22, valid=1, overrun=1; STOP sample with valid=1 and ready=1 -> no overrun.
REQ-039 Assert reset during DATA after 3 bits -> all outputs at reset values, next clean frame 0xFF received correctly.
REQ-040 tick every 3rd cycle, send 0x00 -> result and sr_en count identical to tick-every-cycle case.
